// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register slave.
//
// Exposes NUM_REGS 32-bit registers on an AXI4-Lite bus. Register 0 drives CTRL_OUT. The last
// register is a read-only status word that returns STATUS_IN, and writes to it are discarded.
// Addresses with any bit set above the register index field get SLVERR.
// Every output comes straight from a flop.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET          clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*                   write address, write data, write response channels
//   S_AXI_AR*/R*                      read address, read data channels
//   CTRL_OUT                          live contents of register 0
//   STATUS_IN                         value returned by reads of register NUM_REGS-1
module axi_lite_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   CTRL_OUT,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   STATUS_IN
);

  localparam int IdxW  = $clog2(NUM_REGS);
  localparam int StrbW = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [IdxW-1:0] StatusIdx = IdxW'(NUM_REGS - 1);

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

  // Write channel state
  logic                          aw_ready, w_ready;
  logic                          aw_held, w_held;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
  logic [StrbW-1:0]              w_strb;
  logic                          b_valid;
  logic [1:0]                    b_resp;

  // Read channel state
  logic                          ar_ready;
  logic                          r_valid;
  logic [1:0]                    r_resp;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_data;

  // Address decode
  logic [IdxW-1:0]               wr_idx, rd_idx;
  logic                          wr_in_range, rd_in_range;
  logic                          commit;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_value;
  logic [1:0]                    rd_resp;

  assign wr_idx      = aw_addr[IdxW+1:2];
  assign rd_idx      = S_AXI_ARADDR[IdxW+1:2];
  assign wr_in_range = (aw_addr >> (IdxW + 2)) == '0;
  assign rd_in_range = (S_AXI_ARADDR >> (IdxW + 2)) == '0;
  assign commit      = aw_held && w_held;

  always_comb begin
    rd_value = '0;
    rd_resp  = RespSlverr;
    if (rd_in_range) begin
      rd_resp  = RespOkay;
      rd_value = (rd_idx == StatusIdx) ? STATUS_IN : regs[rd_idx];
    end
  end

  // Write address / data acceptance and response generation.
  // A READY re-arms once its channel is empty and no response is pending, or on the B
  // handshake edge itself; the first case also brings READY up right after reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      b_valid  <= 1'b0;
      b_resp   <= RespOkay;
    end else begin
      if (aw_ready && S_AXI_AWVALID) begin
        aw_ready <= 1'b0;
        aw_held  <= 1'b1;
        aw_addr  <= S_AXI_AWADDR;
      end else if (!aw_ready && !aw_held && (!b_valid || S_AXI_BREADY)) begin
        aw_ready <= 1'b1;
      end

      if (w_ready && S_AXI_WVALID) begin
        w_ready <= 1'b0;
        w_held  <= 1'b1;
        w_data  <= S_AXI_WDATA;
        w_strb  <= S_AXI_WSTRB;
      end else if (!w_ready && !w_held && (!b_valid || S_AXI_BREADY)) begin
        w_ready <= 1'b1;
      end

      // READY is low while a channel is held, so the handshake and commit never collide
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        b_valid <= 1'b1;
        b_resp  <= wr_in_range ? RespOkay : RespSlverr;
      end else if (b_valid && S_AXI_BREADY) begin
        b_valid <= 1'b0;
      end
    end
  end

  // Register bank. The status slot is never written and always reads STATUS_IN.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit && wr_in_range && (wr_idx != StatusIdx)) begin
      for (int b = 0; b < StrbW; b++) begin
        if (w_strb[b]) begin
          regs[wr_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

  // Read path: data is captured at the AR handshake, so a same-edge commit is not visible.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_resp   <= RespOkay;
    end else begin
      if (ar_ready && S_AXI_ARVALID) begin
        ar_ready <= 1'b0;
        r_valid  <= 1'b1;
        r_data   <= rd_value;
        r_resp   <= rd_resp;
      end else if (r_valid && S_AXI_RREADY) begin
        r_valid  <= 1'b0;
        ar_ready <= 1'b1;
      end else if (!ar_ready && !r_valid) begin
        ar_ready <= 1'b1;
      end
    end
  end

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = w_ready;
  assign S_AXI_BVALID  = b_valid;
  assign S_AXI_BRESP   = b_resp;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RVALID  = r_valid;
  assign S_AXI_RDATA   = r_data;
  assign S_AXI_RRESP   = r_resp;
  assign CTRL_OUT      = regs[0];

  // Protection bits and byte offsets carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
module tb_axi_lite_reg_slave;

  localparam int AW   = 8;
  localparam int NREG = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, ctrl_out, status_in;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int npass = 0;
  int nfail = 0;
  int nchk  = 0;

  logic [31:0] mdl [NREG];

  always #5 clk = ~clk;

  axi_lite_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(AW),
    .NUM_REGS          (NREG)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .CTRL_OUT     (ctrl_out),
    .STATUS_IN    (status_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: a byte-addressed register file described by the address map rules
  task automatic mdl_reset();
    for (int i = 0; i < NREG; i++) mdl[i] = 32'h0;
  endtask

  task automatic mdl_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int idx;
    idx = int'(a) / 4;
    if (int'(a) >= NREG * 4) begin
      resp = 2'b10;
    end else begin
      resp = 2'b00;
      if (idx != NREG - 1)
        for (int b = 0; b < 4; b++)
          if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic mdl_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    int idx;
    idx = int'(a) / 4;
    if (int'(a) >= NREG * 4) begin
      d = 32'h0;
      resp = 2'b10;
    end else begin
      resp = 2'b00;
      d = (idx == NREG - 1) ? status_in : mdl[idx];
    end
  endtask

  // All drive/sample activity happens at the falling edge; every task starts and ends there.
  task automatic write_txn(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic got);
    logic hs_aw, hs_w;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    got = 1'b0; resp = 2'bxx;
    for (int n = 0; n < 20 && (awvalid || wvalid); n++) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(negedge clk);
      if (hs_aw) awvalid = 1'b0;
      if (hs_w) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bvalid) begin
        got = 1'b1;
        resp = bresp;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic read_txn(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output logic got);
    logic hs;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    got = 1'b0; d = 'x; resp = 2'bxx;
    for (int n = 0; n < 20 && arvalid; n++) begin
      hs = arvalid && arready;
      @(negedge clk);
      if (hs) arvalid = 1'b0;
    end
    arvalid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (rvalid) begin
        got = 1'b1;
        d = rdata;
        resp = rresp;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // Full write through both the DUT and the model, checking the response
  task automatic write_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    logic [1:0] r, er;
    logic got;
    write_txn(a, d, s, r, got);
    mdl_write(a, d, s, er);
    check({tag, " bvalid seen"}, {31'h0, got}, 32'h1);
    check({tag, " bresp"}, {30'h0, r}, {30'h0, er});
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a);
    logic [31:0] d, ed;
    logic [1:0] r, er;
    logic got;
    mdl_read(a, ed, er);
    read_txn(a, d, r, got);
    check({tag, " rvalid seen"}, {31'h0, got}, 32'h1);
    check({tag, " rdata"}, d, ed);
    check({tag, " rresp"}, {30'h0, r}, {30'h0, er});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d1, d2, rd;
    logic [1:0]  r;
    logic        got;
    int          bseen;

    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    status_in = 32'h12345678;
    mdl_reset();

    // Reset and release
    repeat (3) @(negedge clk);
    check("reset awready", {31'h0, awready}, 32'h0);
    check("reset wready", {31'h0, wready}, 32'h0);
    check("reset arready", {31'h0, arready}, 32'h0);
    check("reset bvalid/rvalid", {30'h0, bvalid, rvalid}, 32'h0);
    check("reset ctrl_out", ctrl_out, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset readies", {29'h0, awready, wready, arready}, 32'h7);
    read_chk("reg0 after reset", 8'h00);

    // AW and W together, exact B latency
    awaddr = 8'h04; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("joint hs readies low", {30'h0, awready, wready}, 32'h0);
    check("joint hs bvalid not yet", {31'h0, bvalid}, 32'h0);
    @(negedge clk);
    check("joint bvalid", {31'h0, bvalid}, 32'h1);
    check("joint bresp", {30'h0, bresp}, 32'h0);
    mdl_write(8'h04, 32'hDEADBEEF, 4'hF, r);
    @(negedge clk);
    check("joint b done", {31'h0, bvalid}, 32'h0);
    check("joint readies back", {30'h0, awready, wready}, 32'h3);
    read_chk("reg1 readback", 8'h04);

    // W three cycles ahead of AW, partial strobes
    write_chk("preload reg2", 8'h08, 32'hAABBCCDD, 4'hF);
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("w-first wready held low", {31'h0, wready}, 32'h0);
      check("w-first no bvalid", {31'h0, bvalid}, 32'h0);
      @(negedge clk);
    end
    awaddr = 8'h08; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("w-first wready after aw", {31'h0, wready}, 32'h0);
    @(negedge clk);
    check("w-first bvalid", {31'h0, bvalid}, 32'h1);
    check("w-first wready during b", {31'h0, wready}, 32'h0);
    mdl_write(8'h08, 32'h11223344, 4'b0101, r);
    @(negedge clk);
    check("w-first wready after b", {31'h0, wready}, 32'h1);
    read_chk("reg2 merged", 8'h08);
    check("reg2 merged literal", mdl[2], 32'hAA22CC44);

    // BREADY withheld; second write must wait, reads proceed
    d1 = $urandom;
    d2 = $urandom;
    awaddr = 8'h0C; awvalid = 1'b1; wdata = d1; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("stall bvalid", {31'h0, bvalid}, 32'h1);
    mdl_write(8'h0C, d1, 4'hF, r);
    awaddr = 8'h10; awvalid = 1'b1; wdata = d2; wvalid = 1'b1;
    read_chk("read during stall", 8'h04);
    for (int k = 0; k < 5; k++) begin
      check("stall bvalid held", {31'h0, bvalid}, 32'h1);
      check("stall readies low", {30'h0, awready, wready}, 32'h0);
      check("stall bresp", {30'h0, bresp}, 32'h0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    check("stall released", {31'h0, bvalid}, 32'h0);
    write_chk("second write", 8'h10, d2, 4'hF);
    read_chk("reg3 first write", 8'h0C);
    read_chk("reg4 second write", 8'h10);

    // Out-of-range and status register
    write_chk("oor write", 8'h40, $urandom, 4'hF);
    read_chk("oor read", 8'h40);
    for (int i = 0; i < NREG; i++) read_chk("bank intact", AW'(i * 4));
    write_chk("status write", 8'h3C, 32'h5, 4'hF);
    read_chk("status read", 8'h3C);

    // Reset right after an AW-only handshake
    awaddr = 8'h00; awvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    bseen = 0;
    for (int k = 0; k < 8; k++) begin
      if (bvalid) bseen++;
      @(negedge clk);
    end
    check("no b after reset", 32'(bseen), 32'h0);
    check("ctrl_out cleared", ctrl_out, 32'h0);
    write_chk("ctrl write", 8'h00, 32'h1, 4'hF);
    check("ctrl_out set", ctrl_out, 32'h1);

    // Randomised traffic against the model
    for (int it = 0; it < 60; it++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) status_in = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        write_chk("rand write", a, $urandom, 4'($urandom));
        check("rand ctrl_out", ctrl_out, mdl[0]);
      end else begin
        read_chk("rand read", a);
      end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
